// File: rtl/datapath_run_monitor.sv
// Run controller and write-back trace monitor for the single-cycle RISC-V datapath.
// Sequences core reset, runs until PC self-loop or cycle timeout, and records register write-backs.
module datapath_run_monitor #(
  parameter  int XLEN        = 32,
  parameter  int HOLD_CYCLES = 2,
  parameter  int MAX_CYCLES  = 32,
  parameter  int STALL_LIMIT = 4,
  parameter  int TRACE_DEPTH = 16,
  localparam int AW          = $clog2(TRACE_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] PCVal,
  input  logic [XLEN-1:0] WB,
  input  logic            RegWEn,
  output logic            core_reset,
  output logic            running,
  output logic            done,
  output logic [1:0]      done_cause,
  output logic [15:0]     cycle_count,
  output logic [AW:0]     trace_count,
  output logic            trace_overflow,
  input  logic [AW-1:0]   trace_rd_addr,
  output logic [XLEN-1:0] trace_rd_data
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [15:0]   MAX_L   = 16'(MAX_CYCLES);
  localparam logic [SW-1:0] STALL_L = SW'(STALL_LIMIT);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [HW-1:0]     r_hold_cnt;
  logic [SW-1:0]     r_stall_cnt;
  logic [XLEN-1:0]   r_prev_pc;
  logic              r_pc_valid;
  logic [15:0]       r_cycle_count;
  logic [AW:0]       r_trace_count;
  logic              r_overflow;
  logic [1:0]        r_cause;
  logic [XLEN-1:0]   r_trace [TRACE_DEPTH];

  logic [15:0]       w_cycle_inc;
  logic [SW-1:0]     w_stall_nxt;
  logic              w_stall_hit;
  logic              w_timeout;
  logic              w_trace_we;
  logic              w_rd_valid;

  // The first RUN cycle has no previous PC, so r_pc_valid gates the compare.
  assign w_cycle_inc = r_cycle_count + 16'd1;
  assign w_stall_nxt = (r_pc_valid && (PCVal == r_prev_pc)) ? r_stall_cnt + SW'(1) : '0;
  assign w_stall_hit = (w_stall_nxt == STALL_L);
  assign w_timeout   = (w_cycle_inc == MAX_L);
  assign w_trace_we  = (r_state == S_RUN) && RegWEn && (r_trace_count != DEPTH_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    core_reset  = 1'b1;
    running     = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_HOLD;
      S_HOLD: if (r_hold_cnt == HW'(1)) w_state_nxt = S_RUN;
      S_RUN: begin
        core_reset = 1'b0;
        running    = 1'b1;
        if (w_stall_hit || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_prev_pc     <= '0;
      r_pc_valid    <= 1'b0;
      r_cycle_count <= '0;
      r_trace_count <= '0;
      r_overflow    <= 1'b0;
      r_cause       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_hold_cnt    <= HW'(HOLD_CYCLES);
            r_stall_cnt   <= '0;
            r_pc_valid    <= 1'b0;
            r_cycle_count <= '0;
            r_trace_count <= '0;
            r_overflow    <= 1'b0;
            r_cause       <= 2'b00;
          end
        end
        S_HOLD: begin
          r_hold_cnt <= r_hold_cnt - HW'(1);
          r_pc_valid <= 1'b0;
        end
        S_RUN: begin
          r_cycle_count <= w_cycle_inc;
          r_stall_cnt   <= w_stall_nxt;
          r_prev_pc     <= PCVal;
          r_pc_valid    <= 1'b1;
          if (RegWEn) begin
            if (r_trace_count != DEPTH_L) r_trace_count <= r_trace_count + (AW + 1)'(1);
            else                          r_overflow    <= 1'b1;
          end
          // Stall takes priority when both end conditions coincide.
          if (w_stall_hit)    r_cause <= 2'b01;
          else if (w_timeout) r_cause <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_trace_we) r_trace[r_trace_count[AW-1:0]] <= WB;
  end

  assign w_rd_valid = ({1'b0, trace_rd_addr} < r_trace_count);

  always_comb begin
    trace_rd_data = '0;
    if (w_rd_valid) trace_rd_data = r_trace[trace_rd_addr];
  end

  assign done_cause     = r_cause;
  assign cycle_count    = r_cycle_count;
  assign trace_count    = r_trace_count;
  assign trace_overflow = r_overflow;

endmodule

// File: tb/tb_datapath_run_monitor.sv
// Directed bench for datapath_run_monitor: default instance plus a variant whose
// stall limit and timeout coincide.
module tb_datapath_run_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_b;
  logic [31:0] pc, wb;
  logic        regwen;
  logic [3:0]  rd_addr, rd_addr_b;

  logic        core_reset, running, done, overflow;
  logic [1:0]  cause;
  logic [15:0] cyc;
  logic [4:0]  tcount;
  logic [31:0] rd_data;

  logic        core_reset_b, running_b, done_b, overflow_b;
  logic [1:0]  cause_b;
  logic [15:0] cyc_b;
  logic [4:0]  tcount_b;
  logic [31:0] rd_data_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  datapath_run_monitor u_dut (
    .clk(clk), .reset(reset), .start(start), .PCVal(pc), .WB(wb), .RegWEn(regwen),
    .core_reset(core_reset), .running(running), .done(done), .done_cause(cause),
    .cycle_count(cyc), .trace_count(tcount), .trace_overflow(overflow),
    .trace_rd_addr(rd_addr), .trace_rd_data(rd_data)
  );

  datapath_run_monitor #(.MAX_CYCLES(8), .STALL_LIMIT(7)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .PCVal(pc), .WB(wb), .RegWEn(regwen),
    .core_reset(core_reset_b), .running(running_b), .done(done_b), .done_cause(cause_b),
    .cycle_count(cyc_b), .trace_count(tcount_b), .trace_overflow(overflow_b),
    .trace_rd_addr(rd_addr_b), .trace_rd_data(rd_data_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then step through the two HOLD cycles into RUN.
  task automatic do_start(input bit on_b);
    if (on_b) start_b = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start_b = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_b = 1'b0;
    pc = '0; wb = '0; regwen = 1'b0; rd_addr = '0; rd_addr_b = '0;
    #1;
    check_val("rst_core_reset", 32'(core_reset), 32'd1);
    check_val("rst_running",    32'(running),    32'd0);
    check_val("rst_done",       32'(done),       32'd0);
    check_val("rst_cause",      32'(cause),      32'd0);
    check_val("rst_cycles",     32'(cyc),        32'd0);
    check_val("rst_tcount",     32'(tcount),     32'd0);
    check_val("rst_overflow",   32'(overflow),   32'd0);
    check_val("rst_rd_data",    rd_data,         32'd0);

    // T1: hold sequencing
    tick();
    reset = 1'b0;
    tick();
    check_val("idle_core_reset", 32'(core_reset), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("hold1_core_reset", 32'(core_reset), 32'd1);
    check_val("hold1_running",    32'(running),    32'd0);
    tick();
    check_val("hold2_core_reset", 32'(core_reset), 32'd1);
    check_val("hold2_running",    32'(running),    32'd0);
    tick();
    check_val("run_core_reset", 32'(core_reset), 32'd0);
    check_val("run_running",    32'(running),    32'd1);
    check_val("run_done",       32'(done),       32'd0);
    check_val("run_cycles0",    32'(cyc),        32'd0);

    // T2: PC advances every cycle, run ends by timeout at 32
    for (int k = 1; k <= 32; k++) begin
      pc = 32'(4 * k);
      tick();
      if (k == 1)  check_val("t2_cycles1", 32'(cyc), 32'd1);
      if (k == 31) check_val("t2_running31", 32'(running), 32'd1);
    end
    check_val("t2_done",       32'(done),       32'd1);
    check_val("t2_running",    32'(running),    32'd0);
    check_val("t2_core_reset", 32'(core_reset), 32'd1);
    check_val("t2_cause",      32'(cause),      32'd2);
    check_val("t2_cycles",     32'(cyc),        32'd32);
    check_val("t2_tcount",     32'(tcount),     32'd0);
    pc = 32'h200;
    tick();
    check_val("t2_frozen_cycles", 32'(cyc),  32'd32);
    check_val("t2_frozen_done",   32'(done), 32'd1);

    // T3: PC sticks at 0x40 from RUN cycle 10, stall limit reached at cycle 14
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("t3_clear_cycles", 32'(cyc),   32'd0);
    check_val("t3_clear_done",   32'(done),  32'd0);
    check_val("t3_clear_cause",  32'(cause), 32'd0);
    tick();
    tick();
    for (int k = 1; k <= 14; k++) begin
      pc = (k < 10) ? 32'(4 * (k - 1)) : 32'h40;
      tick();
      if (k == 13) check_val("t3_running13", 32'(running), 32'd1);
    end
    check_val("t3_done",   32'(done),  32'd1);
    check_val("t3_cause",  32'(cause), 32'd1);
    check_val("t3_cycles", 32'(cyc),   32'd14);

    // T4: write-back every cycle, trace saturates at 16, stall ends run at cycle 21
    do_start(1'b0);
    for (int k = 1; k <= 21; k++) begin
      regwen = 1'b1;
      wb = 32'(k - 1);
      pc = (k <= 17) ? 32'(4 * k) : 32'd68;
      tick();
      if (k == 16) begin
        check_val("t4_tcount16", 32'(tcount),   32'd16);
        check_val("t4_ovf16",    32'(overflow), 32'd0);
      end
      if (k == 17) check_val("t4_ovf17", 32'(overflow), 32'd1);
      if (k == 20) check_val("t4_running20", 32'(running), 32'd1);
    end
    regwen = 1'b0;
    check_val("t4_done",     32'(done),     32'd1);
    check_val("t4_cause",    32'(cause),    32'd1);
    check_val("t4_cycles",   32'(cyc),      32'd21);
    check_val("t4_tcount",   32'(tcount),   32'd16);
    check_val("t4_overflow", 32'(overflow), 32'd1);
    rd_addr = 4'd5;  #1; check_val("t4_rd5",  rd_data, 32'd5);
    rd_addr = 4'd15; #1; check_val("t4_rd15", rd_data, 32'd15);
    rd_addr = 4'd10; #1; check_val("t4_rd10", rd_data, 32'd10);

    // T5: asynchronous reset between edges in the middle of a run
    do_start(1'b0);
    for (int k = 1; k <= 5; k++) begin
      regwen = 1'b1;
      wb = 32'hA0 + 32'(k);
      pc = 32'(4 * k);
      tick();
    end
    check_val("t5_pre_tcount",  32'(tcount),  32'd5);
    check_val("t5_pre_running", 32'(running), 32'd1);
    regwen = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_val("t5_core_reset", 32'(core_reset), 32'd1);
    check_val("t5_running",    32'(running),    32'd0);
    check_val("t5_cycles",     32'(cyc),        32'd0);
    check_val("t5_tcount",     32'(tcount),     32'd0);
    check_val("t5_rd_masked",  rd_data,         32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_val("t5_idle_running", 32'(running), 32'd0);
    do_start(1'b0);
    for (int k = 1; k <= 3; k++) begin
      regwen = 1'b1;
      wb = 32'h55 + 32'(k);
      pc = 32'h300 + 32'(4 * k);
      tick();
    end
    regwen = 1'b0;
    rd_addr = 4'd0;
    #1;
    check_val("t5_again_cycles", 32'(cyc),    32'd3);
    check_val("t5_again_tcount", 32'(tcount), 32'd3);
    check_val("t5_again_rd0",    rd_data,     32'h56);

    // T6: stall limit and timeout coincide; start during RUN is ignored
    pc = 32'h100;
    do_start(1'b1);
    check_val("t6_running0", 32'(running_b), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) start_b = 1'b1;
      tick();
      start_b = 1'b0;
      if (k == 3) begin
        check_val("t6_ign_running", 32'(running_b), 32'd1);
        check_val("t6_ign_cycles",  32'(cyc_b),     32'd3);
      end
      if (k == 7) check_val("t6_running7", 32'(running_b), 32'd1);
    end
    check_val("t6_done",   32'(done_b),  32'd1);
    check_val("t6_cause",  32'(cause_b), 32'd1);
    check_val("t6_cycles", 32'(cyc_b),   32'd8);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check_val("t6_restart_cycles", 32'(cyc_b),        32'd0);
    check_val("t6_restart_done",   32'(done_b),       32'd0);
    check_val("t6_restart_cause",  32'(cause_b),      32'd0);
    check_val("t6_restart_creset", 32'(core_reset_b), 32'd1);
    tick();
    tick();
    check_val("t6_restart_running", 32'(running_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
